// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // LO result of a divide by zero; sliced to the unit width (up to 64 bits)
  localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate: o_val = i_neg ? -i_val : i_val.
module mdu_abs_neg #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? ('0 - i_val) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// Optional build macro MULTDIV_EARLY_OUT_EN ends a multiply once no multiplier bits remain.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_hi_wr,
  input  logic             i_lo_wr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  state_e             r_state, w_state_nxt;
  op_e                r_op;
  logic               r_neg_q, r_neg_r, r_div0, r_done;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [WIDTH-1:0]   r_mplier, r_hi, r_lo;

  op_e                w_op_in;
  logic               w_sa, w_sb, w_is_div, w_last, w_early, w_ge;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quot_fix, w_rem_src, w_rem_fix, w_rem_nxt;
  logic [WIDTH-1:0]   w_hi_res, w_lo_res;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH+1:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod_sum, w_prod_fix;

  assign w_op_in  = op_e'(i_op);
  assign w_sa     = ((w_op_in == OP_MULT) || (w_op_in == OP_DIV)) && i_a[WIDTH-1];
  assign w_sb     = ((w_op_in == OP_MULT) || (w_op_in == OP_DIV)) && i_b[WIDTH-1];
  assign w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_last   = (r_cnt == CW'(ITER - 1));

`ifdef MULTDIV_EARLY_OUT_EN
  assign w_early = !w_is_div && (r_mplier == '0);
`else
  assign w_early = 1'b0;
`endif

  mdu_abs_neg #(.W(WIDTH)) u_mag_a (.i_val(i_a), .i_neg(w_sa), .o_val(w_a_mag));
  mdu_abs_neg #(.W(WIDTH)) u_mag_b (.i_val(i_b), .i_neg(w_sb), .o_val(w_b_mag));

  // Multiply step: accumulate the shifted multiplicand when the next multiplier bit is set
  assign w_prod_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Divide step: remainder in r_acc upper half, dividend bits shift out of r_mplier
  assign w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_mplier[WIDTH-1]};
  assign w_diff    = {1'b0, w_trial} - {2'b00, r_mcand[WIDTH-1:0]};
  assign w_ge      = !w_diff[WIDTH+1];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

  // Divide by zero returns the dividend magnitude, re-signed back to the original a
  assign w_rem_src = r_div0 ? r_mcand[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  mdu_abs_neg #(.W(2*WIDTH)) u_fix_p (.i_val(r_acc), .i_neg(r_neg_q), .o_val(w_prod_fix));
  mdu_abs_neg #(.W(WIDTH)) u_fix_q (.i_val(r_mplier), .i_neg(r_neg_q), .o_val(w_quot_fix));
  mdu_abs_neg #(.W(WIDTH)) u_fix_r (.i_val(w_rem_src), .i_neg(r_neg_r), .o_val(w_rem_fix));

  assign w_hi_res = w_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_lo_res = !w_is_div ? w_prod_fix[WIDTH-1:0] :
                    r_div0    ? DIV0_LO[WIDTH-1:0]    : w_quot_fix;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_early || w_last) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op     <= OP_MULT;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= (r_state == ST_FIX);
      case (r_state)
        ST_IDLE: begin
          if (i_hi_wr) r_hi <= i_wdata;
          if (i_lo_wr) r_lo <= i_wdata;
          if (i_start) begin
            r_op    <= w_op_in;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_div0  <= (i_b == '0);
            r_cnt   <= '0;
            r_acc   <= '0;
            if (i_op[1]) begin
              r_mcand  <= {w_a_mag, w_b_mag};
              r_mplier <= w_a_mag;
            end else begin
              r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
              r_mplier <= w_b_mag;
            end
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_is_div) begin
            r_acc[2*WIDTH-1:WIDTH] <= w_rem_nxt;
            r_mplier               <= {r_mplier[WIDTH-2:0], w_ge};
          end else begin
            r_acc    <= w_prod_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
        end
        ST_FIX: begin
          r_hi <= w_hi_res;
          r_lo <= w_lo_res;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops vs. an arithmetic model.
module tb_mult_div_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_a, i_b, i_wdata;
  logic        i_hi_wr, i_lo_wr;
  logic        o_busy, o_done;
  logic [31:0] o_hi, o_lo;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_hi_wr (i_hi_wr),
    .i_lo_wr (i_lo_wr),
    .i_wdata (i_wdata),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_hi    (o_hi),
    .o_lo    (o_lo)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Architectural results from plain 64-bit arithmetic
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = 64'(a) * 64'(b); eh = p[63:32]; el = p[31:0]; end
      2'b10: begin
        if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0]; end
      end
      default: begin
        if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin eh = a % b; el = a / b; end
      end
    endcase
  endtask

  // Edges from the start edge to the edge after which done is seen
  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] m;
    int          len;
    int          lat;
    lat = 33;
`ifdef MULTDIV_EARLY_OUT_EN
    if (!op[1]) begin
      m   = (op == 2'b00 && b[31]) ? (32'd0 - b) : b;
      len = 0;
      for (int i = 0; i < 32; i++) if (m[i]) len = i + 1;
      lat = (len + 2 < 33) ? len + 2 : 33;
    end
`else
    m   = b;
    len = op;
`endif
    return lat;
  endfunction

  // Launch one op, optionally injecting start+MTHI at busy cycle 'inject', and check outcome
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inject, input string tag);
    logic [31:0] eh, el;
    int          lat;
    model(op, a, b, eh, el);
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_op    = 2'($urandom);
    i_a     = $urandom;
    i_b     = $urandom;
    chk({tag, " busy after start"}, 64'(o_busy), 64'd1);
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == inject) begin
        i_start = 1'b1; i_op = 2'b00; i_a = 32'd2; i_b = 32'd2;
        i_hi_wr = 1'b1; i_wdata = 32'h1234;
      end
      @(posedge i_clk); #1;
      if (c == inject) begin i_start = 1'b0; i_hi_wr = 1'b0; end
      if (o_done) begin lat = c; break; end
      chk({tag, " busy in flight"}, 64'(o_busy), 64'd1);
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_latency(op, b)));
    chk({tag, " busy at done"}, 64'(o_busy), 64'd0);
    chk({tag, " hi"}, 64'(o_hi), 64'(eh));
    chk({tag, " lo"}, 64'(o_lo), 64'(el));
  endtask

  initial begin
    logic [31:0] a, b, hold_hi, hold_lo;
    logic [1:0]  op;
    int          seen;

    i_rst_n = 1'b0; i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0;
    i_hi_wr = 1'b0; i_lo_wr = 1'b0; i_wdata = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset busy", 64'(o_busy), 64'd0);
    chk("reset done", 64'(o_done), 64'd0);
    chk("reset hi", 64'(o_hi), 64'd0);
    chk("reset lo", 64'(o_lo), 64'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu max");
    chk("multu max hi literal", 64'(o_hi), 64'hFFFF_FFFE);
    chk("multu max lo literal", 64'(o_lo), 64'h0000_0001);
    @(posedge i_clk); #1;
    chk("done one cycle", 64'(o_done), 64'd0);

    run_op(2'b00, -32'sd7, 32'd3, 0, "mult -7*3");
    chk("mult -7*3 lo literal", 64'(o_lo), 64'hFFFF_FFEB);
    // Back-to-back: next start is taken in the done cycle
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, "mult min*min");
    chk("mult min*min hi literal", 64'(o_hi), 64'h4000_0000);
    run_op(2'b10, -32'sd7, 32'd2, 0, "div -7/2");
    chk("div -7/2 lo literal", 64'(o_lo), 64'hFFFF_FFFD);
    chk("div -7/2 hi literal", 64'(o_hi), 64'hFFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd7, 0, "divu 100/7");
    chk("divu 100/7 lo literal", 64'(o_lo), 64'd14);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div overflow");
    chk("div overflow lo literal", 64'(o_lo), 64'h8000_0000);
    chk("div overflow hi literal", 64'(o_hi), 64'd0);
    run_op(2'b11, 32'd5, 32'd0, 0, "divu by zero");
    chk("divu by zero hi literal", 64'(o_hi), 64'd5);
    run_op(2'b10, -32'sd9, 32'd0, 0, "div by zero neg");
    run_op(2'b11, 32'd100, 32'd7, 5, "busy inputs ignored");
    chk("busy ignored lo literal", 64'(o_lo), 64'd14);
    chk("busy ignored hi literal", 64'(o_hi), 64'd2);

    run_op(2'b01, 32'd9, 32'd0, 0, "multu 9*0");
    run_op(2'b01, 32'd9, 32'd1, 0, "multu 9*1");
    chk("multu 9*1 lo literal", 64'(o_lo), 64'd9);
    @(posedge i_clk); #1;

    i_hi_wr = 1'b1; i_lo_wr = 1'b1; i_wdata = 32'hA5A5_A5A5;
    @(posedge i_clk); #1;
    i_hi_wr = 1'b0; i_lo_wr = 1'b0;
    chk("mt both hi", 64'(o_hi), 64'hA5A5_A5A5);
    chk("mt both lo", 64'(o_lo), 64'hA5A5_A5A5);
    i_hi_wr = 1'b1; i_wdata = 32'h1111_1111;
    @(posedge i_clk); #1;
    i_hi_wr = 1'b0;
    chk("mthi hi", 64'(o_hi), 64'h1111_1111);
    chk("mthi lo held", 64'(o_lo), 64'hA5A5_A5A5);

    // MTHI together with start: accepted now, overwritten at completion
    i_op = 2'b01; i_a = 32'd3; i_b = 32'd4; i_start = 1'b1;
    i_hi_wr = 1'b1; i_wdata = 32'h0000_DEAD;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_hi_wr = 1'b0;
    chk("mt with start hi", 64'(o_hi), 64'h0000_DEAD);
    seen = 0;
    for (int c = 0; c < 60 && seen == 0; c++) begin
      @(posedge i_clk); #1;
      if (o_done) seen = 1;
    end
    chk("mt with start done", 64'(seen), 64'd1);
    chk("mt with start hi result", 64'(o_hi), 64'd0);
    chk("mt with start lo result", 64'(o_lo), 64'd12);

    // Reset in the middle of an operation
    @(posedge i_clk); #1;
    i_op = 2'b11; i_a = 32'd1000; i_b = 32'd3; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    chk("midreset busy", 64'(o_busy), 64'd0);
    chk("midreset done", 64'(o_done), 64'd0);
    chk("midreset hi", 64'(o_hi), 64'd0);
    chk("midreset lo", 64'(o_lo), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge i_clk); #1;
      if (o_done || o_busy) seen = 1;
    end
    chk("midreset no done", 64'(seen), 64'd0);

    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(0, 15));
        2:       a = 32'h8000_0000;
        3:       b = 32'($urandom_range(0, 255)) << $urandom_range(0, 20);
        default: ;
      endcase
      run_op(op, a, b, 0, "random");
      if (n % 2 == 0) begin
        hold_hi = o_hi;
        hold_lo = o_lo;
        model(op, a, b, hold_hi, hold_lo);
        @(posedge i_clk); #1;
        chk("random done pulse width", 64'(o_done), 64'd0);
        chk("random hi held", 64'(o_hi), 64'(hold_hi));
        chk("random lo held", 64'(o_lo), 64'(hold_lo));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
